// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-side program counter stage.
package pc_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] INSTR_BYTES          = 32'd4;

endpackage

// File: rtl/pc_unit_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pc_unit.sv
// Program counter stage: sequential/branch next-PC, branch-to-self halt,
// sticky misalignment flag and saturating performance counters.
module pc_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             PCsrc,
  input  logic [31:0]      ImmOp,
  input  logic             resume,
  output logic [31:0]      PC,
  output logic             halted,
  output logic             misaligned,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        misaligned_q, misaligned_d;
  logic        cyc_inc, ret_inc;
  logic [31:0] target, seq;

  assign target = pc_q + ImmOp;
  assign seq    = pc_q + INSTR_BYTES;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    misaligned_d = misaligned_q;
    cyc_inc      = 1'b0;
    ret_inc      = 1'b0;
    case (state_q)
      RUN: begin
        cyc_inc = 1'b1;
        if (!en) begin
          pc_d = pc_q;
        end else if (!PCsrc) begin
          pc_d    = seq;
          ret_inc = 1'b1;
        end else if (target[1:0] != 2'b00) begin
          // Faulting branch is not committed; the core parks for inspection.
          misaligned_d = 1'b1;
          state_d      = HALT;
        end else if (ImmOp == 32'd0) begin
          ret_inc = 1'b1;
          state_d = HALT;
        end else begin
          pc_d    = target;
          ret_inc = 1'b1;
        end
      end
      HALT: begin
        if (resume) begin
          pc_d    = seq;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      pc_q         <= RESET_VECTOR;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cyc_inc),
    .q     (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_retired_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ret_inc),
    .q     (retired_cnt)
  );

  assign PC         = pc_q;
  assign halted     = (state_q == HALT);
  assign misaligned = misaligned_q;

endmodule
